// File: rtl/gpu_clk_pkg.sv
// Shared types and default timing constants for the GPU clock-tree supervisor.
package gpu_clk_pkg;

  typedef enum logic [2:0] {
    PLL_RESET = 3'd0,
    WAIT_LOCK = 3'd1,
    RELEASE   = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } pll_seq_state_e;

  localparam int unsigned DEF_NUM_OUTS            = 2;
  localparam int unsigned DEF_SYNC_STAGES         = 2;
  localparam int unsigned DEF_PLL_RST_CYCLES      = 16;
  localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 50000;
  localparam int unsigned DEF_RELEASE_STAGGER     = 8;
  localparam int unsigned DEF_MAX_RETRIES         = 4;
  localparam int unsigned DEF_CNT_W               = 8;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// N-flop single-bit synchroniser, asynchronous active-low reset to 0.
module bit_synchronizer #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[STAGES-2:0], d};
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/gpu_pll_reset_sequencer.sv
// PLL supervisor: pulses PLL reset, qualifies lock, retries on timeout and
// releases downstream domain resets in staggered order.
module gpu_pll_reset_sequencer
  import gpu_clk_pkg::*;
#(
  parameter int unsigned NUM_OUTS            = DEF_NUM_OUTS,
  parameter int unsigned SYNC_STAGES         = DEF_SYNC_STAGES,
  parameter int unsigned PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
  parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int unsigned RELEASE_STAGGER     = DEF_RELEASE_STAGGER,
  parameter int unsigned MAX_RETRIES         = DEF_MAX_RETRIES,
  parameter int unsigned CNT_W               = DEF_CNT_W
) (
  input  logic                refclk,
  input  logic                rst_n,
  input  logic                locked_i,
  input  logic                sw_relock_i,
  output logic                pll_rst_o,
  output logic [NUM_OUTS-1:0] domain_rst_n_o,
  output logic                ready_o,
  output logic                fail_o,
  output logic [2:0]          state_o,
  output logic [CNT_W-1:0]    loss_cnt_o,
  output logic [CNT_W-1:0]    timeout_cnt_o
);

  localparam int unsigned TW = $clog2(max3(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES,
                                           RELEASE_STAGGER) + 1);
  localparam int unsigned SW = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int unsigned RW = $clog2(MAX_RETRIES + 1);
  localparam int unsigned IW = $clog2(NUM_OUTS + 1);

  localparam logic [TW-1:0] PLL_RST_LAST = TW'(PLL_RST_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] STAGGER_LAST = TW'(RELEASE_STAGGER - 1);
  localparam logic [SW-1:0] STABLE_LAST  = SW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_LAST   = RW'(MAX_RETRIES - 1);
  localparam logic [IW-1:0] ALL_RELEASED = IW'(NUM_OUTS);

  pll_seq_state_e      state_q, state_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [SW-1:0]       stable_q, stable_d;
  logic [RW-1:0]       retry_q, retry_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [NUM_OUTS-1:0] dom_q, dom_d;
  logic [CNT_W-1:0]    loss_q, loss_d;
  logic [CNT_W-1:0]    tmo_q, tmo_d;
  logic                lk;

  bit_synchronizer #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (locked_i),
    .q     (lk)
  );

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= PLL_RESET;
      timer_q  <= '0;
      stable_q <= '0;
      retry_q  <= '0;
      idx_q    <= '0;
      dom_q    <= '0;
      loss_q   <= '0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      stable_q <= stable_d;
      retry_q  <= retry_d;
      idx_q    <= idx_d;
      dom_q    <= dom_d;
      loss_q   <= loss_d;
      tmo_q    <= tmo_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    stable_d = stable_q;
    retry_d  = retry_q;
    idx_d    = idx_q;
    dom_d    = dom_q;
    loss_d   = loss_q;
    tmo_d    = tmo_q;

    // Software relock outranks lock loss, so a coincident loss is not counted.
    if (sw_relock_i && state_q != PLL_RESET) begin
      state_d  = PLL_RESET;
      timer_d  = '0;
      stable_d = '0;
      retry_d  = '0;
      idx_d    = '0;
      dom_d    = '0;
    end else begin
      case (state_q)
        PLL_RESET: begin
          dom_d = '0;
          if (timer_q == PLL_RST_LAST) begin
            state_d  = WAIT_LOCK;
            timer_d  = '0;
            stable_d = '0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        WAIT_LOCK: begin
          timer_d  = timer_q + TW'(1);
          stable_d = lk ? stable_q + SW'(1) : '0;
          if (lk && stable_q == STABLE_LAST) begin
            state_d  = RELEASE;
            timer_d  = '0;
            stable_d = '0;
            retry_d  = '0;
            dom_d    = NUM_OUTS'(1);
            idx_d    = IW'(1);
          end else if (timer_q == TIMEOUT_LAST) begin
            timer_d  = '0;
            stable_d = '0;
            retry_d  = retry_q + RW'(1);
            tmo_d    = (tmo_q == '1) ? tmo_q : tmo_q + CNT_W'(1);
            state_d  = (retry_q == RETRY_LAST) ? FAIL : PLL_RESET;
          end
        end
        RELEASE, RUN: begin
          if (!lk) begin
            state_d  = PLL_RESET;
            timer_d  = '0;
            idx_d    = '0;
            dom_d    = '0;
            loss_d   = (loss_q == '1) ? loss_q : loss_q + CNT_W'(1);
          end else if (state_q == RELEASE) begin
            if (idx_q == ALL_RELEASED) begin
              state_d = RUN;
              timer_d = '0;
            end else if (timer_q == STAGGER_LAST) begin
              timer_d = '0;
              idx_d   = idx_q + IW'(1);
              for (int unsigned k = 0; k < NUM_OUTS; k++) begin
                if (IW'(k) == idx_q) dom_d[k] = 1'b1;
              end
            end else begin
              timer_d = timer_q + TW'(1);
            end
          end
        end
        FAIL: ;
        default: state_d = PLL_RESET;
      endcase
    end
  end

  assign pll_rst_o      = (state_q == PLL_RESET) || (state_q == FAIL);
  assign domain_rst_n_o = dom_q;
  assign ready_o        = (state_q == RUN);
  assign fail_o         = (state_q == FAIL);
  assign state_o        = state_q;
  assign loss_cnt_o     = loss_q;
  assign timeout_cnt_o  = tmo_q;

endmodule

// File: tb/tb_gpu_pll_reset_sequencer.sv
// Directed and randomized bench for gpu_pll_reset_sequencer against a phase/elapsed-time model.
module tb_gpu_pll_reset_sequencer;

  localparam int N    = 3;
  localparam int PRST = 4;
  localparam int STB  = 8;
  localparam int TMO  = 64;
  localparam int STG  = 3;
  localparam int MR   = 2;
  localparam int SY   = 2;
  localparam int CW   = 2;

  localparam int P_RST = 0, P_WAIT = 1, P_REL = 2, P_RUN = 3, P_FAIL = 4;

  logic          refclk = 1'b0;
  logic          rst_n, locked_i, sw_relock_i;
  logic          pll_rst_o, ready_o, fail_o;
  logic [N-1:0]  domain_rst_n_o;
  logic [2:0]    state_o;
  logic [CW-1:0] loss_cnt_o, timeout_cnt_o;

  int checks = 0;
  int errors = 0;

  int m_phase, m_el, m_hi, m_tries, m_loss, m_tmo;
  bit lkq[$];

  always #5 refclk = ~refclk;

  gpu_pll_reset_sequencer #(
    .NUM_OUTS(N), .SYNC_STAGES(SY), .PLL_RST_CYCLES(PRST), .LOCK_STABLE_CYCLES(STB),
    .LOCK_TIMEOUT_CYCLES(TMO), .RELEASE_STAGGER(STG), .MAX_RETRIES(MR), .CNT_W(CW)
  ) dut (
    .refclk(refclk), .rst_n(rst_n), .locked_i(locked_i), .sw_relock_i(sw_relock_i),
    .pll_rst_o(pll_rst_o), .domain_rst_n_o(domain_rst_n_o), .ready_o(ready_o),
    .fail_o(fail_o), .state_o(state_o), .loss_cnt_o(loss_cnt_o),
    .timeout_cnt_o(timeout_cnt_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v == (1 << CW) - 1) ? v : v + 1;
  endfunction

  task automatic enter(input int p);
    m_phase = p;
    m_el    = 0;
    m_hi    = 0;
  endtask

  task automatic model_reset();
    enter(P_RST);
    m_tries = 0;
    m_loss  = 0;
    m_tmo   = 0;
    lkq.delete();
    for (int i = 0; i < SY; i++) lkq.push_back(1'b0);
  endtask

  // One clock edge: lk is the locked_i value sampled SY edges earlier.
  task automatic model_step();
    bit lk;
    lk = lkq[0];
    if (sw_relock_i && m_phase != P_RST) begin
      enter(P_RST);
      m_tries = 0;
    end else begin
      case (m_phase)
        P_RST: if (m_el + 1 == PRST) enter(P_WAIT); else m_el++;
        P_WAIT: begin
          m_hi = lk ? m_hi + 1 : 0;
          if (m_hi == STB) begin
            enter(P_REL);
            m_tries = 0;
          end else if (m_el + 1 == TMO) begin
            m_tmo = sat(m_tmo);
            m_tries++;
            enter((m_tries == MR) ? P_FAIL : P_RST);
          end else m_el++;
        end
        P_REL, P_RUN: begin
          if (!lk) begin
            m_loss = sat(m_loss);
            enter(P_RST);
          end else if (m_phase == P_REL) begin
            if (m_el == (N - 1) * STG) enter(P_RUN); else m_el++;
          end
        end
        default: ;
      endcase
    end
    lkq.push_back(locked_i);
    lk = lkq.pop_front();
  endtask

  task automatic check_all();
    int dom;
    dom = 0;
    if (m_phase == P_REL) dom = (1 << (m_el / STG + 1)) - 1;
    if (m_phase == P_RUN) dom = (1 << N) - 1;
    chk("state", state_o, m_phase);
    chk("pll_rst", pll_rst_o, (m_phase == P_RST || m_phase == P_FAIL) ? 1 : 0);
    chk("domain_rst_n", domain_rst_n_o, dom);
    chk("ready", ready_o, (m_phase == P_RUN) ? 1 : 0);
    chk("fail", fail_o, (m_phase == P_FAIL) ? 1 : 0);
    chk("loss_cnt", loss_cnt_o, m_loss);
    chk("timeout_cnt", timeout_cnt_o, m_tmo);
  endtask

  task automatic tick();
    @(posedge refclk);
    model_step();
    @(negedge refclk);
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge refclk);
    @(negedge refclk);
    rst_n = 1'b1;
  endtask

  task automatic wait_phase(input int p, input string tag);
    for (int i = 0; i < 400 && m_phase != p; i++) tick();
    chk(tag, state_o, p);
  endtask

  initial begin
    int first;
    rst_n = 1'b0; locked_i = 1'b0; sw_relock_i = 1'b0;
    model_reset();

    // 1: locked throughout; domain 0 at tick 12, ready at tick 19
    locked_i = 1'b1;
    do_reset();
    first = 0;
    for (int t = 1; t <= 25; t++) begin
      tick();
      if (first == 0 && domain_rst_n_o != '0) first = t;
      if (t == 19) chk("t1_ready_at_19", ready_o, 1);
      if (t == 18) chk("t1_not_ready_at_18", ready_o, 0);
    end
    chk("t1_first_release_tick", first, 12);

    // 2: one-cycle glitch restarts the stable count
    do_reset();
    first = 0;
    for (int t = 1; t <= 30; t++) begin
      locked_i = (t == 6) ? 1'b0 : 1'b1;
      tick();
      if (first == 0 && domain_rst_n_o != '0) first = t;
    end
    chk("t2_first_release_tick", first, 16);

    // 3: stuck unlocked -> two timeouts -> FAIL, then relock
    locked_i = 1'b0;
    do_reset();
    wait_phase(P_FAIL, "t3_reach_fail");
    chk("t3_timeouts", timeout_cnt_o, 2);
    chk("t3_fail", fail_o, 1);
    chk("t3_pll_rst", pll_rst_o, 1);
    sw_relock_i = 1'b1;
    tick();
    sw_relock_i = 1'b0;
    chk("t3_relock_state", state_o, P_RST);
    chk("t3_relock_fail", fail_o, 0);

    // 4: lock drop in RUN, visible 3 cycles later
    locked_i = 1'b1;
    do_reset();
    wait_phase(P_RUN, "t4_reach_run");
    locked_i = 1'b0;
    tick(); tick();
    chk("t4_still_released", domain_rst_n_o, 3'b111);
    tick();
    chk("t4_domains", domain_rst_n_o, 3'b000);
    chk("t4_loss", loss_cnt_o, 1);
    chk("t4_state", state_o, P_RST);

    // 5: relock coincident with synced loss; then rst_n during RELEASE
    locked_i = 1'b1;
    wait_phase(P_RUN, "t5_reach_run");
    locked_i = 1'b0;
    tick(); tick();
    sw_relock_i = 1'b1;
    tick();
    sw_relock_i = 1'b0;
    chk("t5_state", state_o, P_RST);
    chk("t5_loss_unchanged", loss_cnt_o, 1);
    locked_i = 1'b1;
    wait_phase(P_REL, "t5_reach_release");
    tick(); tick(); tick();
    do_reset();
    chk("t5_reset_domains", domain_rst_n_o, 3'b000);

    // 6: five losses saturate the 2-bit counter
    for (int n = 0; n < 5; n++) begin
      locked_i = 1'b1;
      wait_phase(P_RUN, "t6_reach_run");
      locked_i = 1'b0;
      tick(); tick(); tick();
    end
    chk("t6_loss_sat", loss_cnt_o, 3);

    // Random lock behaviour and occasional relock requests
    locked_i = 1'b1;
    do_reset();
    for (int t = 0; t < 600; t++) begin
      if (t % 150 < 100) locked_i = ($urandom_range(0, 29) != 0);
      else               locked_i = ($urandom_range(0, 3) == 0);
      sw_relock_i = ($urandom_range(0, 79) == 0);
      tick();
    end
    sw_relock_i = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
